// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type and default sizing for rr_arbiter
package arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    localparam int ARB_N        = 8;
    localparam int ARB_MAX_HOLD = 16;

endpackage

// File: rtl/arb_prio_enc.sv
// arb_prio_enc: lowest-set-bit encoder, index 0 wins, plus any-set flag
module arb_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            idx = req[i] ? IDX_W'(i) : idx;
    end

    assign any = |req;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: registered N-way fixed/round-robin arbiter with bounded hold
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             rr_en,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] base, enc_idx, win;
    logic [N-1:0]     req_rot;
    logic             enc_any, withdrawn, expired, release_g;

    // Fixed mode is just round-robin with the search base pinned at 0
    assign base = rr_en ? ptr_q : '0;

    always_comb begin
        req_rot = '0;
        for (int i = 0; i < N; i++)
            req_rot[i] = req[IDX_W'(i) + base];
    end

    arb_prio_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_enc (
        .req (req_rot),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign win       = enc_idx + base;
    assign withdrawn = !req[gnt_idx_q];
    assign expired   = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    assign release_g = done || withdrawn || expired;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        if (state_q == IDLE) begin
            if (enc_any) begin
                state_d     = BUSY;
                gnt_d       = N'(1) << win;
                gnt_idx_d   = win;
                gnt_valid_d = 1'b1;
                cnt_d       = '0;
                ptr_d       = rr_en ? win + 1'b1 : ptr_q;
            end
        end else if (release_g) begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            cnt_d       = '0;
            timeout_d   = expired && !done && !withdrawn;
        end else begin
            cnt_d = (MAX_HOLD == 0) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed and random checks of rr_arbiter against a search-based model
module tb_rr_arbiter;

    localparam int N    = 8;
    localparam int HOLD = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         rr_en;
    logic         done;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_idx;
    logic         gnt_valid;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    bit m_busy;
    bit m_to;
    int m_owner;
    int m_ptr;
    int m_hold;

    rr_arbiter #(
        .N        (N),
        .MAX_HOLD (HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rr_en     (rr_en),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_to    = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), m_busy ? 32'(1) << m_owner : 32'd0);
        chk({tag, "_idx"}, 32'(gnt_idx), m_busy ? 32'(m_owner) : 32'd0);
        chk({tag, "_valid"}, 32'(gnt_valid), 32'(m_busy));
        chk({tag, "_timeout"}, 32'(timeout), 32'(m_to));
    endtask

    // One clock: model predicts from pre-edge inputs, DUT sampled 1 time unit after the edge
    task automatic tick();
        bit nb, nt;
        int no, np, nh, start;
        nb = m_busy;
        nt = 1'b0;
        no = m_owner;
        np = m_ptr;
        nh = m_hold;
        if (!m_busy) begin
            if (req != '0) begin
                start = rr_en ? m_ptr : 0;
                for (int k = N - 1; k >= 0; k--)
                    if (req[(start + k) % N]) no = (start + k) % N;
                nb = 1'b1;
                nh = 0;
                if (rr_en) np = (no + 1) % N;
            end
        end else if (done || !req[m_owner] || m_hold == HOLD - 1) begin
            nt = !done && req[m_owner];
            nb = 1'b0;
            nh = 0;
        end else begin
            nh = m_hold + 1;
        end
        @(posedge clk);
        m_busy  = nb;
        m_to    = nt;
        m_owner = no;
        m_ptr   = np;
        m_hold  = nh;
        #1;
        chk_model("model");
    endtask

    task automatic sync_reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        rr_en = 1'b0;
        done  = 1'b0;
        model_reset();
        #3;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_idx", 32'(gnt_idx), 32'd0);
        chk("reset_valid", 32'(gnt_valid), 32'd0);
        chk("reset_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // fixed priority
        rr_en = 1'b0;
        req   = 8'b1010_0100;
        tick();
        chk("fix_first_gnt", 32'(gnt), 32'h04);
        chk("fix_first_idx", 32'(gnt_idx), 32'd2);
        done = 1'b1;
        req  = 8'b1010_0000;
        tick();
        chk("fix_bubble", 32'(gnt), 32'h00);
        done = 1'b0;
        tick();
        chk("fix_second_idx", 32'(gnt_idx), 32'd5);
        done = 1'b1;
        req  = 8'b1000_0000;
        tick();
        done = 1'b0;
        tick();
        chk("fix_third_idx", 32'(gnt_idx), 32'd7);
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;

        // round-robin fairness
        rr_en = 1'b1;
        req   = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick();
            chk("rr_seq_idx", 32'(gnt_idx), 32'(g % N));
            done = 1'b1;
            tick();
            chk("rr_bubble", 32'(gnt_valid), 32'd0);
            done = 1'b0;
        end
        req = '0;
        tick();

        // wrap-around from ptr 6
        sync_reset_pulse();
        rr_en = 1'b1;
        req   = 8'b0010_0000;
        tick();
        chk("wrap_setup_idx", 32'(gnt_idx), 32'd5);
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;
        req  = 8'b0000_0011;
        tick();
        chk("wrap_idx", 32'(gnt_idx), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("wrap_ptr1_idx", 32'(gnt_idx), 32'd1);
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;

        // timeout after exactly HOLD cycles
        rr_en = 1'b0;
        req   = 8'b0000_1000;
        tick();
        chk("to_gnt_c1", 32'(gnt), 32'h08);
        for (int c = 2; c <= HOLD; c++) begin
            tick();
            chk("to_gnt_held", 32'(gnt), 32'h08);
            chk("to_no_pulse", 32'(timeout), 32'd0);
        end
        tick();
        chk("to_release_gnt", 32'(gnt), 32'h00);
        chk("to_pulse", 32'(timeout), 32'd1);
        tick();
        chk("to_pulse_end", 32'(timeout), 32'd0);
        req = '0;
        tick();
        tick();

        // withdrawal in the last hold cycle
        req = 8'b0000_1000;
        tick();
        for (int c = 1; c < HOLD; c++) tick();
        req = '0;
        tick();
        chk("wd_gnt", 32'(gnt), 32'h00);
        chk("wd_timeout", 32'(timeout), 32'd0);

        // done in the last hold cycle
        req = 8'b0000_1000;
        tick();
        for (int c = 1; c < HOLD; c++) tick();
        done = 1'b1;
        tick();
        chk("done_gnt", 32'(gnt), 32'h00);
        chk("done_timeout", 32'(timeout), 32'd0);
        done = 1'b0;
        req  = '0;
        tick();

        // async reset mid-grant, then pointer restarts at 0
        rr_en = 1'b1;
        req   = 8'b0001_0000;
        tick();
        chk("ar_grant_idx", 32'(gnt_idx), 32'd4);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_gnt", 32'(gnt), 32'h00);
        chk("ar_idx", 32'(gnt_idx), 32'd0);
        chk("ar_valid", 32'(gnt_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'b0011_0000;
        tick();
        chk("ar_ptr0_idx", 32'(gnt_idx), 32'd4);
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;
        req  = 8'h80;
        tick();
        chk("ar_top_idx", 32'(gnt_idx), 32'd7);
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;

        // random traffic against the model
        for (int r = 0; r < 400; r++) begin
            req   = N'($urandom) & N'($urandom);
            done  = ($urandom_range(0, 3) == 0);
            rr_en = ($urandom_range(0, 7) != 0) ? rr_en : !rr_en;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
